// File: rtl/rf_wb_pkg.sv
// Shared widths and the queue entry type for the register-file write-back queue.
package rf_wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_fwd_match.sv
// Youngest-first forwarding search over the pending queue entries and the
// output register for one decode read port.
module rf_wb_fwd_match
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wb_entry_t                      entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]       head,
    input  logic [$clog2(DEPTH+1)-1:0]     count,
    input  logic                           out_valid,
    input  wb_entry_t                      out_entry,
    input  logic [REG_AW-1:0]              rr,
    output logic                           hit,
    output logic [XLEN-1:0]                data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so that later (younger) matches overwrite older ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        if (out_valid && out_entry.rd == rr) begin
            hit  = 1'b1;
            data = out_entry.data;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && entries[idx].rd == rr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
        if (rr == '0) begin
            hit  = 1'b0;
            data = '0;
        end
    end

endmodule

// File: rtl/rf_wb_queue.sv
// Two-producer write-back queue draining one result per cycle into the
// register file write port, with read-side forwarding of pending writes.
module rf_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = rf_wb_pkg::XLEN,
    parameter int unsigned AW    = rf_wb_pkg::REG_AW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_valid,
    input  logic [AW-1:0]                a_rd,
    input  logic [XLEN-1:0]              a_data,
    output logic                         a_ready,
    input  logic                         b_valid,
    input  logic [AW-1:0]                b_rd,
    input  logic [XLEN-1:0]              b_data,
    output logic                         b_ready,
    output logic                         wen,
    output logic [AW-1:0]                wR,
    output logic [XLEN-1:0]              wD,
    input  logic [AW-1:0]                rR1,
    input  logic [AW-1:0]                rR2,
    output logic                         fwd1_hit,
    output logic                         fwd2_hit,
    output logic [XLEN-1:0]              fwd1_data,
    output logic [XLEN-1:0]              fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    import rf_wb_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    wb_entry_t     q_mem [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] free;
    logic          wen_q;
    wb_entry_t     out_q;

    logic          a_fire;
    logic          b_fire;
    logic          a_push;
    logic          b_push;
    logic          pop;
    logic [PW-1:0] b_slot;
    wb_entry_t     a_ent;
    wb_entry_t     b_ent;

    // Free space is judged on the pre-pop count: a slot popped this cycle
    // only becomes usable on the next one.
    assign free    = CW'(DEPTH) - count_q;
    assign a_ready = !rst && (free >= CW'(1));
    assign b_ready = !rst && (free >= (a_valid ? CW'(2) : CW'(1)));

    assign a_fire = a_valid && a_ready;
    assign b_fire = b_valid && b_ready;
    // Writes to x0 complete the handshake but are dropped.
    assign a_push = a_fire && (a_rd != '0);
    assign b_push = b_fire && (b_rd != '0);
    assign pop    = (count_q != '0);

    assign b_slot = a_push ? tail_q + PW'(1) : tail_q;

    always_comb begin
        a_ent      = '0;
        a_ent.rd   = a_rd;
        a_ent.data = a_data;
        b_ent      = '0;
        b_ent.rd   = b_rd;
        b_ent.data = b_data;
    end

    assign count_d = count_q + CW'(a_push) + CW'(b_push) - CW'(pop);

    // Entry storage needs no reset: only slots between head and tail are observed.
    always_ff @(posedge clk) begin
        if (a_push) q_mem[tail_q] <= a_ent;
        if (b_push) q_mem[b_slot] <= b_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wen_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            tail_q  <= tail_q + PW'(a_push) + PW'(b_push);
            head_q  <= head_q + PW'(pop);
            count_q <= count_d;
            wen_q   <= pop;
            if (pop) out_q <= q_mem[head_q];
        end
    end

    assign wen   = wen_q;
    assign wR    = out_q.rd;
    assign wD    = out_q.data;
    assign count = count_q;

    rf_wb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd1 (
        .entries   (q_mem),
        .head      (head_q),
        .count     (count_q),
        .out_valid (wen_q),
        .out_entry (out_q),
        .rr        (rR1),
        .hit       (fwd1_hit),
        .data      (fwd1_data)
    );

    rf_wb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd2 (
        .entries   (q_mem),
        .head      (head_q),
        .count     (count_q),
        .out_valid (wen_q),
        .out_entry (out_q),
        .rr        (rR2),
        .hit       (fwd2_hit),
        .data      (fwd2_data)
    );

endmodule

// File: tb/tb_rf_wb_queue.sv
// Randomized and directed bench for rf_wb_queue against an in-order queue model.
module tb_rf_wb_queue;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        wen;
    logic [4:0]  wR;
    logic [31:0] wD;
    logic [4:0]  rR1, rR2;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: pending entries oldest-first, plus the write-port register.
    ent_t        m_q[$];
    logic        m_wen;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    always #5 clk = ~clk;

    rf_wb_queue #(
        .DEPTH (DEPTH),
        .XLEN  (32),
        .AW    (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .wen       (wen),
        .wR        (wR),
        .wD        (wD),
        .rR1       (rR1),
        .rR2       (rR2),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data),
        .count     (count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Youngest pending write to rr, falling back to the register being written.
    task automatic model_fwd(input logic [4:0] rr, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        if (rr != 0) begin
            for (int i = m_q.size() - 1; i >= 0; i--) begin
                if (!hit && m_q[i].rd == rr) begin
                    hit  = 1'b1;
                    data = m_q[i].data;
                end
            end
            if (!hit && m_wen && m_wr == rr) begin
                hit  = 1'b1;
                data = m_wd;
            end
        end
    endtask

    task automatic step(input logic r,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                        input logic [4:0] r1, input logic [4:0] r2);
        int          free;
        logic        ea, eb, h;
        logic [31:0] d;
        ent_t        e;
        rst = r; a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd; rR1 = r1; rR2 = r2;
        #1;
        free = DEPTH - m_q.size();
        ea   = !r && (free >= 1);
        eb   = !r && (free >= (av ? 2 : 1));
        check_eq("a_ready", a_ready, ea);
        check_eq("b_ready", b_ready, eb);
        check_eq("count", count, m_q.size());
        check_eq("wen", wen, m_wen);
        check_eq("wR", wR, m_wr);
        check_eq("wD", wD, m_wd);
        model_fwd(r1, h, d);
        check_eq("fwd1_hit", fwd1_hit, h);
        check_eq("fwd1_data", fwd1_data, d);
        model_fwd(r2, h, d);
        check_eq("fwd2_hit", fwd2_hit, h);
        check_eq("fwd2_data", fwd2_data, d);
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_wen = 1'b0;
            m_wr  = '0;
            m_wd  = '0;
        end else begin
            if (m_q.size() > 0) begin
                e     = m_q.pop_front();
                m_wen = 1'b1;
                m_wr  = e.rd;
                m_wd  = e.data;
            end else begin
                m_wen = 1'b0;
            end
            if (av && ea && ard != 0) m_q.push_back('{rd: ard, data: ad});
            if (bv && eb && brd != 0) m_q.push_back('{rd: brd, data: bd});
        end
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
    endtask

    initial begin
        m_wen = 1'b0; m_wr = '0; m_wd = '0;
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_rd = '0; b_rd = '0;
        a_data = '0; b_data = '0; rR1 = '0; rR2 = '0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 5'd9, 5'd0);

        // Single A write, then forwarding from queue and output register.
        step(1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        check_eq("first_wR", wR, 5'd5);
        check_eq("first_wD", wD, 32'h11);
        idle(3, 5'd5, 5'd6);

        // Same rd on both ports in one cycle: B is younger.
        step(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 5'd3, 5'd3);
        idle(4, 5'd3, 5'd4);

        // Saturate both ports.
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 5'(2 * i + 1), 32'(100 + i), 1'b1, 5'(2 * i + 2), 32'(200 + i),
                 5'(i + 1), 5'(i + 2));
        idle(6, 5'd2, 5'd7);

        // rd=0 handshakes are dropped.
        step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        idle(2, 5'd0, 5'd1);

        // Fill to 3 then reset: nothing pending may be written.
        step(1'b0, 1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11, 5'd10, 5'd11);
        step(1'b0, 1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13, 5'd12, 5'd13);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd11, 5'd12);
        idle(3, 5'd12, 5'd13);

        // Sequential writes across the pointer wrap.
        for (int i = 1; i <= 7; i++)
            step(1'b0, 1'b1, 5'(i), 32'(32'hC0 + i), 1'b0, 5'd0, 32'd0, 5'(i), 5'(i - 1));
        idle(3, 5'd7, 5'd6);

        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 60) == 0),
                 ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
